// File: rtl/noc_pkg.sv
// Shared NOC router definitions: port indices, one-hot turn encodings and
// the rotation helpers used by the per-output round-robin turn slices.
package noc_pkg;

  localparam int PORT_N = 4;
  localparam int PORT_S = 3;
  localparam int PORT_E = 2;
  localparam int PORT_W = 1;
  localparam int PORT_L = 0;

  typedef logic [4:0] turn_t;

  localparam turn_t TURN_N = 5'b10000;
  localparam turn_t TURN_S = 5'b01000;
  localparam turn_t TURN_E = 5'b00100;
  localparam turn_t TURN_W = 5'b00010;
  localparam turn_t TURN_L = 5'b00001;

  // One step in N->S->E->W->L->N order is a right rotate with wrap.
  function automatic turn_t turn_rotate(turn_t t);
    return {t[0], t[4:1]};
  endfunction

  // First requester found stepping from one past turn; turn itself excluded.
  // Returns all-zero when no other input is requesting.
  function automatic turn_t turn_next_req(turn_t turn, turn_t req);
    turn_t cand;
    turn_t res;
    cand = turn_rotate(turn);
    res  = '0;
    for (int i = 0; i < 4; i++) begin
      if (res == '0 && (cand & req) != '0) res = cand;
      cand = turn_rotate(cand);
    end
    return res;
  endfunction

endpackage

// File: rtl/turn_rr_slice.sv
// One output's round-robin turn register. TURN_SKIP_EN selects work-conserving
// jumps to the next requester; otherwise the turn moves one position per cycle.
module turn_rr_slice
  import noc_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  turn_t req,
  input  logic  enable,
  output turn_t turn
);

  turn_t turn_nxt;
  logic  holder_req;

  assign holder_req = |(req & turn);

`ifdef TURN_SKIP_EN
  turn_t others;
  assign others = req & ~turn;

  always_comb begin
    turn_nxt = turn;
    if (enable) begin
      turn_nxt = (others != '0) ? turn_next_req(turn, req) : turn_rotate(turn);
    end else if (!holder_req && req != '0) begin
      turn_nxt = turn_next_req(turn, req);
    end
  end
`else
  // Any move collapses to a single step; an idle holder costs one cycle each.
  always_comb begin
    turn_nxt = turn;
    if (enable || (!holder_req && req != '0)) begin
      turn_nxt = turn_rotate(turn);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      turn <= TURN_N;
    end else begin
      turn <= turn_nxt;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && enable && !holder_req) begin
      $display("turn_rr_slice %m: enable without request (turn=%b req=%b)", turn, req);
    end
  end
`endif

endmodule

// File: rtl/turn_scheduler.sv
// Five independent round-robin turn slices, one per router output (N,S,E,W,L).
// Optional macro TURN_SKIP_EN enables work-conserving turn jumps.
module turn_scheduler
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] N_req,
  input  logic [NUM_PORTS-1:0] S_req,
  input  logic [NUM_PORTS-1:0] E_req,
  input  logic [NUM_PORTS-1:0] W_req,
  input  logic [NUM_PORTS-1:0] L_req,
  input  logic                 N_port_enable,
  input  logic                 S_port_enable,
  input  logic                 E_port_enable,
  input  logic                 W_port_enable,
  input  logic                 L_port_enable,
  output logic [NUM_PORTS-1:0] N_turn,
  output logic [NUM_PORTS-1:0] S_turn,
  output logic [NUM_PORTS-1:0] E_turn,
  output logic [NUM_PORTS-1:0] W_turn,
  output logic [NUM_PORTS-1:0] L_turn
);

  if (NUM_PORTS != 5) begin : g_bad_num_ports
    $error("turn_scheduler: NUM_PORTS must be 5");
  end

  turn_rr_slice u_n (.clk(clk), .rst(rst), .req(N_req), .enable(N_port_enable), .turn(N_turn));
  turn_rr_slice u_s (.clk(clk), .rst(rst), .req(S_req), .enable(S_port_enable), .turn(S_turn));
  turn_rr_slice u_e (.clk(clk), .rst(rst), .req(E_req), .enable(E_port_enable), .turn(E_turn));
  turn_rr_slice u_w (.clk(clk), .rst(rst), .req(W_req), .enable(W_port_enable), .turn(W_turn));
  turn_rr_slice u_l (.clk(clk), .rst(rst), .req(L_req), .enable(L_port_enable), .turn(L_turn));

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler; expectations follow TURN_SKIP_EN so the
// same file covers both the skip and single-step builds.
module tb_turn_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] N_req, S_req, E_req, W_req, L_req;
  logic       N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable;
  logic [4:0] N_turn, S_turn, E_turn, W_turn, L_turn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  turn_scheduler #(.NUM_PORTS(5)) dut (
    .clk(clk), .rst(rst),
    .N_req(N_req), .S_req(S_req), .E_req(E_req), .W_req(W_req), .L_req(L_req),
    .N_port_enable(N_port_enable), .S_port_enable(S_port_enable),
    .E_port_enable(E_port_enable), .W_port_enable(W_port_enable),
    .L_port_enable(L_port_enable),
    .N_turn(N_turn), .S_turn(S_turn), .E_turn(E_turn), .W_turn(W_turn), .L_turn(L_turn)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] exp);
    chk({tag, "_N"}, N_turn, exp);
    chk({tag, "_S"}, S_turn, exp);
    chk({tag, "_E"}, E_turn, exp);
    chk({tag, "_W"}, W_turn, exp);
    chk({tag, "_L"}, L_turn, exp);
  endtask

  initial begin
    logic [4:0] e_exp [$];
    logic [4:0] e_cur;

    // Reset with arbitrary request/enable values
    rst = 1'b1;
    N_req = 5'($urandom_range(0, 31)); S_req = 5'($urandom_range(0, 31));
    E_req = 5'($urandom_range(0, 31)); W_req = 5'($urandom_range(0, 31));
    L_req = 5'($urandom_range(0, 31));
    N_port_enable = 1'($urandom_range(0, 1)); S_port_enable = 1'($urandom_range(0, 1));
    E_port_enable = 1'($urandom_range(0, 1)); W_port_enable = 1'($urandom_range(0, 1));
    L_port_enable = 1'($urandom_range(0, 1));
    step();
    chk_all("reset1", 5'b10000);
    step();
    chk_all("reset2", 5'b10000);

    rst = 1'b0;
    N_req = '0; S_req = '0; E_req = '0; W_req = '0; L_req = '0;
    N_port_enable = 0; S_port_enable = 0; E_port_enable = 0; W_port_enable = 0; L_port_enable = 0;
    step();
    chk_all("idle_hold", 5'b10000);

    // Idle holder: S asks for W, W asks for L, concurrently
    S_req = 5'b00010;
    W_req = 5'b00001;
`ifdef TURN_SKIP_EN
    step(); chk("skip_s1", S_turn, 5'b00010); chk("skip_w1", W_turn, 5'b00001);
    step(); chk("skip_s2", S_turn, 5'b00010); chk("skip_w2", W_turn, 5'b00001);
`else
    step(); chk("ss_s1", S_turn, 5'b01000); chk("ss_w1", W_turn, 5'b01000);
    step(); chk("ss_s2", S_turn, 5'b00100); chk("ss_w2", W_turn, 5'b00100);
    step(); chk("ss_s3", S_turn, 5'b00010); chk("ss_w3", W_turn, 5'b00010);
    step(); chk("ss_s4", S_turn, 5'b00010); chk("ss_w4", W_turn, 5'b00001);
    step(); chk("ss_s5", S_turn, 5'b00010); chk("ss_w5", W_turn, 5'b00001);
`endif
    chk("idle_n", N_turn, 5'b10000);
    S_req = '0; W_req = '0;

    // Full rotation on E, E input (00100) never requesting; enable follows holder
`ifdef TURN_SKIP_EN
    e_exp = '{5'b01000, 5'b00010, 5'b00001, 5'b10000, 5'b01000};
`else
    e_exp = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
`endif
    E_req = 5'b11011;
    e_cur = 5'b10000;
    foreach (e_exp[i]) begin
      E_port_enable = |(E_req & e_cur);
      step();
      chk($sformatf("rot_e%0d", i), E_turn, e_exp[i]);
      e_cur = e_exp[i];
    end
    E_port_enable = 0; E_req = '0;
    step();
    chk("rot_e_hold", E_turn, e_cur);

    // Blocked holder on L
    L_req = 5'b10100;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("blk_l%0d", i), L_turn, 5'b10000);
    end
    L_port_enable = 1;
    step();
    L_port_enable = 0;
`ifdef TURN_SKIP_EN
    chk("blk_l_grant", L_turn, 5'b00100);
    step();
    chk("blk_l_after", L_turn, 5'b00100);
`else
    chk("blk_l_grant", L_turn, 5'b01000);
    step();
    chk("blk_l_after", L_turn, 5'b00100);
`endif
    L_req = '0;

    // Mid-operation reset: bring N to 00010 then reset with enable asserted
    N_req = 5'b00010;
`ifndef TURN_SKIP_EN
    step(); step();
`endif
    step();
    chk("mid_n_pre", N_turn, 5'b00010);
    N_req = 5'b00011;
    N_port_enable = 1;
    rst = 1'b1;
    step();
    chk_all("mid_rst", 5'b10000);
    rst = 1'b0;
    N_port_enable = 0;
    step();
`ifdef TURN_SKIP_EN
    chk("mid_resume", N_turn, 5'b00010);
`else
    chk("mid_resume", N_turn, 5'b01000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
